psram_spi_responder: RTL and testbench
======================================

# psram_spi_responder

Behavioural SPI responder (mode 0) that emulates a small serial PSRAM and answers the SPI initiator already in the psram directory. It oversamples `sclk`, `mosi` and `cs_n` on the system clock, decodes WRITE, READ and READ-ID commands, and serves an internal byte memory. It sits on the far side of the SPI pins, in benches and in loop-back FPGA builds, as the target for the initiator.

## Interface
Parameters:
- `MEM_BYTES`, default 1024: memory size; a power of two, at most 65536.
- `ID0`, default 8'h0D: first READ-ID byte.
- `ID1`, default 8'h5D: second READ-ID byte.

Ports:
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `cs_n`, input, 1: chip select, active low; asynchronous to `clk`.
- `sclk`, input, 1: SPI clock from the initiator; asynchronous to `clk`.
- `mosi`, input, 1: serial data in, MSB first.
- `miso`, output, 1: serial data out, MSB first.
- `miso_oe`, output, 1: output enable for `miso`; high only while driving read or ID data.
- `busy`, output, 1: synchronised `cs_n` is low (frame in progress).
- `err`, output, 1: one-`clk` pulse when an unsupported opcode is received.
- `last_cmd`, output, 8: opcode of the most recent frame.

## Operation
- Input synchronisers: `cs_n`, `sclk` and `mosi` each pass through a 2-flop synchroniser, then one history flop for edge detection.
- Edge detection:
  - A rise event is a 0→1 change in synchronised `sclk`.
  - A fall event is a 1→0 change.
  - Sampling takes synchronised `mosi` on a rise event.
- Bit counter: 3 bits, wraps every 8 rise events. A byte completes on the 8th rise event.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA, ID, IGNORE.
- State transitions:
  - IDLE→CMD on synchronised `cs_n` falling; the bit counter clears.
  - CMD, on byte complete:
    - The opcode is latched into `last_cmd`.
    - 8'h02 or 8'h03 → ADDR_HI.
    - 8'h9F → ID.
    - Any other value → IGNORE and `err` pulses.
  - ADDR_HI→ADDR_LO after one byte.
  - ADDR_LO→WR_DATA (opcode 02) or RD_DATA (opcode 03) after one byte.
  - Address is 16 bits, {ADDR_HI, ADDR_LO}, taken modulo MEM_BYTES.
- WR_DATA:
  - Each completed byte is written to mem[addr] on the next `clk`.
  - addr then increments, wrapping MEM_BYTES-1→0.
- RD_DATA:
  - When entering the state, mem[addr] is loaded into the TX shift register and addr increments.
  - `miso` shows bit 7 of the loaded byte.
  - Each fall event shifts the next bit onto `miso`.
  - After the 8th fall event of a byte, the next byte loads and addr increments. Wrap rules match WR_DATA.
- ID: outputs ID0, then ID1, then 8'h00 for all further bytes. Shifting follows RD_DATA rules.
- IGNORE: consumes bits until the frame ends; `miso_oe`=0.
- `miso_oe` = 1 exactly in RD_DATA and ID. `miso` = 0 whenever `miso_oe` = 0.
- Frame end:
  - Synchronised `cs_n` rising forces IDLE from any state.
  - A partial byte is discarded: no memory write, no addr change.
  - `miso_oe` drops on the same `clk`.
- Memory contents are not reset. Reads of never-written locations are undefined.

## Timing
- Reset values:
  - `miso`=0, `miso_oe`=0, `busy`=0, `err`=0, `last_cmd`=8'h00.
  - State is IDLE; bit counter and addr are 0.
- Pin-to-event latency: 3 `clk` from a pin change to the internal edge event (2 synchroniser stages + 1 history stage).
- `sclk` high and low phases must each be at least 4 `clk` periods. Faster `sclk` is out of spec.
- Read prefetch timing:
  - The first data bit must appear within 2 `clk` after the rise event of address bit 0. One of these cycles covers the synchronous memory read.
  - It is therefore stable at least 2 `clk` before the next `sclk` rise seen at the pin.
- Later bits: `miso` updates 1 `clk` after the fall event.
- `err` is high for exactly 1 `clk`, on the cycle after the CMD byte completes.
- `busy` follows `cs_n` with 2 `clk` latency.
- Asynchronous reset mid-frame:
  - Outputs reach their reset values immediately.
  - An uncommitted byte is lost.
  - The responder waits for `cs_n` high then low before decoding again.
- `cs_n` rising and a byte completing in the same `clk`: the byte completion has priority, so the write commits, and then the state goes to IDLE.

## Test plan
- Write then read back:
  - Frame 02 00 10 A5 3C.
  - Frame 03 00 10 followed by 16 dummy clocks.
  - Required: `miso` reads A5 then 3C; `miso_oe`=1 only during data bytes; `last_cmd`=03.
- Wrap-around:
  - Write 02 03 FF 11 22 (addr 0x3FF with MEM_BYTES=1024).
  - Required: reading at 0x3FF returns 11; reading at 0x000 returns 22.
- READ-ID:
  - Frame 9F with 24 dummy clocks.
  - Required: `miso` returns 0D, 5D, 00; `err` stays 0.
- Bad opcode:
  - Frame 55 followed by 16 clocks.
  - Required: one 1-`clk` pulse on `err`; `miso_oe` stays 0; `last_cmd`=55; memory unchanged.
- Aborted write:
  - Frame 02 00 20 then 4 bits of a data byte, then `cs_n` high.
  - Required: reading 0x0020 returns its prior value (previously written 77). A following normal frame decodes correctly.
- Reset mid-frame:
  - Assert `rst_n`=0 during ADDR_LO.
  - Required: all outputs are at reset values within the same cycle.
  - After release and a fresh frame 03 00 10, the responder returns A5.

Source files
------------

// File: rtl/psram_spi_responder.sv
// psram_spi_responder
//   Behavioural mode-0 SPI target emulating a small serial PSRAM. The SPI pins
//   are oversampled on clk; WRITE (02), READ (03) and READ-ID (9F) are decoded
//   and served from an internal byte memory.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   cs_n      in   chip select (async to clk), active low
//   sclk      in   SPI clock (async to clk)
//   mosi      in   serial data in, MSB first
//   miso      out  serial data out, MSB first (0 when not driving)
//   miso_oe   out  high while driving read or ID data
//   busy      out  synchronised cs_n is low
//   err       out  one-clk pulse on an unsupported opcode
//   last_cmd  out  opcode of the most recent frame
module psram_spi_responder #(
  parameter int         MEM_BYTES = 1024,
  parameter logic [7:0] ID0       = 8'h0D,
  parameter logic [7:0] ID1       = 8'h5D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       busy,
  output logic       err,
  output logic [7:0] last_cmd
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR_HI, ST_ADDR_LO,
    ST_WR_DATA, ST_RD_DATA, ST_ID, ST_IGNORE
  } state_t;

  // Synchroniser and edge-history flops
  logic [1:0] cs_sync_q, cs_sync_d;
  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic       cs_hist_q, cs_hist_d;
  logic       sclk_hist_q, sclk_hist_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;

  // Protocol state
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    addr_hi_q, addr_hi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    tx_q, tx_d;
  logic          load_q, load_d;
  logic          tx_armed_q, tx_armed_d;
  logic [1:0]    id_idx_q, id_idx_d;
  logic          err_q, err_d;
  logic [7:0]    last_cmd_q, last_cmd_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  // Memory (not reset)
  logic [7:0]    mem [MEM_BYTES];
  logic [7:0]    mem_rd_q;
  logic [AW-1:0] mem_rd_addr;

  // Derived events
  logic          cs_s, sclk_s, mosi_s;
  logic          sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]    rx_byte;
  logic          byte_done;
  logic [15:0]   full_addr;

  always_comb begin
    cs_s      = cs_sync_q[1];
    sclk_s    = sclk_sync_q[1];
    mosi_s    = mosi_sync_q[1];
    sclk_rise = sclk_s & ~sclk_hist_q;
    sclk_fall = ~sclk_s & sclk_hist_q;
    // A falling cs_n only starts a frame once cs_n has been seen high after
    // reset, so a reset released mid-frame does not decode the frame's tail.
    cs_fall   = armed_q & ~cs_s & cs_hist_q;
    cs_rise   = cs_s & ~cs_hist_q;
    rx_byte   = {rx_q[6:0], mosi_s};
    byte_done = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
    full_addr = {addr_hi_q, rx_byte};
  end

  // Synchroniser pipeline; settle_q marks when cs_sync_q[1] holds a real pin
  // sample rather than its reset value.
  always_comb begin
    cs_sync_d   = {cs_sync_q[0], cs_n};
    sclk_sync_d = {sclk_sync_q[0], sclk};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    cs_hist_d   = cs_s;
    sclk_hist_d = sclk_s;
    settle_d    = {settle_q[0], 1'b1};
    armed_d     = armed_q | (settle_q[1] & cs_s);
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    addr_hi_d  = addr_hi_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    load_d     = 1'b0;
    tx_armed_d = tx_armed_q;
    id_idx_d   = id_idx_q;
    err_d      = 1'b0;
    last_cmd_d = last_cmd_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if ((state_q != ST_IDLE) && sclk_rise) begin
      rx_d      = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        if (byte_done) begin
          last_cmd_d = rx_byte;
          case (rx_byte)
            8'h02, 8'h03: state_d = ST_ADDR_HI;
            8'h9F: begin
              state_d    = ST_ID;
              tx_d       = ID0;
              id_idx_d   = 2'd1;
              tx_armed_d = 1'b0;
            end
            default: begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_ADDR_HI: begin
        if (byte_done) begin
          addr_hi_d = rx_byte;
          state_d   = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (byte_done) begin
          addr_d = full_addr[AW-1:0];
          if (last_cmd_q == 8'h03) begin
            // The memory read of the first byte happens this edge; the
            // TX register picks it up on the following cycle.
            state_d    = ST_RD_DATA;
            load_d     = 1'b1;
            tx_armed_d = 1'b0;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (byte_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_byte;
          addr_d    = addr_q + AW'(1);
        end
      end
      ST_RD_DATA: begin
        if (load_q) begin
          tx_d   = mem_rd_q;
          addr_d = addr_q + AW'(1);
        end
        // Only a fall that follows a rise inside this state shifts; this
        // skips the fall that trails the last address bit.
        if (sclk_rise) begin
          tx_armed_d = 1'b1;
        end else if (sclk_fall && tx_armed_q) begin
          tx_armed_d = 1'b0;
          if (bit_cnt_q == 3'd0) begin
            tx_d   = mem_rd_q;
            addr_d = addr_q + AW'(1);
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      ST_ID: begin
        if (sclk_rise) begin
          tx_armed_d = 1'b1;
        end else if (sclk_fall && tx_armed_q) begin
          tx_armed_d = 1'b0;
          if (bit_cnt_q == 3'd0) begin
            tx_d     = (id_idx_q == 2'd1) ? ID1 : 8'h00;
            id_idx_d = 2'd2;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: ;
    endcase

    // Frame end wins last so a byte completing on the same cycle still commits.
    if (cs_rise) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      load_d     = 1'b0;
      tx_armed_d = 1'b0;
    end
  end

  // Memory read tracks the next address so data is ready one cycle later
  assign mem_rd_addr = addr_d;

  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    mem_rd_q <= mem[mem_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_hist_q   <= 1'b1;
      sclk_hist_q <= 1'b0;
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      addr_hi_q   <= 8'h00;
      addr_q      <= '0;
      tx_q        <= 8'h00;
      load_q      <= 1'b0;
      tx_armed_q  <= 1'b0;
      id_idx_q    <= 2'd0;
      err_q       <= 1'b0;
      last_cmd_q  <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_hist_q   <= cs_hist_d;
      sclk_hist_q <= sclk_hist_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      load_q      <= load_d;
      tx_armed_q  <= tx_armed_d;
      id_idx_q    <= id_idx_d;
      err_q       <= err_d;
      last_cmd_q  <= last_cmd_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign miso_oe  = (state_q == ST_RD_DATA) || (state_q == ST_ID);
  assign miso     = miso_oe & tx_q[7];
  assign busy     = ~cs_s;
  assign err      = err_q;
  assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_psram_spi_responder.sv
// tb_psram_spi_responder
//   Drives mode-0 SPI frames into psram_spi_responder. Expected read bytes are
//   queued when a frame is issued; a monitor on sclk rises assembles miso bytes
//   and compares them against the queue.
module tb_psram_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic       busy;
  logic       err;
  logic [7:0] last_cmd;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int err_run = 0;
  int mon_bits = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] exp_q[$];

  psram_spi_responder #(
    .MEM_BYTES(1024),
    .ID0(8'h0D),
    .ID1(8'h5D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cs_n(cs_n),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .miso_oe(miso_oe),
    .busy(busy),
    .err(err),
    .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  // Compare one value and report on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Wait n clk edges and settle 2 ns past the edge
  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Shift out the top n bits of b with 5-clk sclk phases
  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      waitClk(5);
      sclk = 1'b1;
      waitClk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic startFrame();
    cs_n = 1'b0;
    waitClk(6);
  endtask

  task automatic endFrame();
    waitClk(6);
    cs_n = 1'b1;
    mosi = 1'b0;
    waitClk(10);
  endtask

  // One full frame: n bytes from the packed vector (first byte in [39:32]),
  // followed by dummy zero bytes
  task automatic applyStimulus(input logic [39:0] bytes, input int n, input int dummy);
    logic [39:0] v;
    v = bytes;
    startFrame();
    for (int k = 0; k < n; k++) sendBits(v[39-8*k -: 8], 8);
    for (int k = 0; k < dummy; k++) sendBits(8'h00, 8);
    endFrame();
  endtask

  // Read-data monitor: the initiator samples miso on sclk rise
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      if (mon_bits != 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL partial_read_byte: got %0d bits expected 0", mon_bits);
      end
      mon_bits = 0;
    end else begin
      checks++;
      if (!miso_oe && miso) begin
        errors++;
        $display("[TB] FAIL miso_idle: got 1 expected 0");
      end
      if (miso_oe) begin
        mon_byte = {mon_byte[6:0], miso};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_read: got %02h expected none", mon_byte);
          end else begin
            checkOutput("read_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // err pulse monitor: each pulse must last exactly one clk
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) begin
        err_run++;
      end else if (err_run != 0) begin
        checkOutput("err_width", 32'(err_run), 32'd1);
        err_pulses++;
        err_run = 0;
      end
    end
  end

  initial begin
    #1ms;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    waitClk(3);
    checkOutput("rst_miso", 32'(miso), 32'd0);
    checkOutput("rst_miso_oe", 32'(miso_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_last_cmd", 32'(last_cmd), 32'd0);
    rst_n = 1'b1;
    waitClk(5);

    // Write then read back
    applyStimulus({8'h02, 8'h00, 8'h10, 8'hA5, 8'h3C}, 5, 0);
    checkOutput("last_cmd_wr", 32'(last_cmd), 32'h02);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    applyStimulus({8'h03, 8'h00, 8'h10, 16'h0000}, 3, 2);
    checkOutput("last_cmd_rd", 32'(last_cmd), 32'h03);
    checkOutput("rd_drained", 32'(exp_q.size()), 32'd0);

    // Wrap-around at the top of memory
    applyStimulus({8'h02, 8'h03, 8'hFF, 8'h11, 8'h22}, 5, 0);
    exp_q.push_back(8'h11);
    applyStimulus({8'h03, 8'h03, 8'hFF, 16'h0000}, 3, 1);
    exp_q.push_back(8'h22);
    applyStimulus({8'h03, 8'h00, 8'h00, 16'h0000}, 3, 1);

    // READ-ID
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h5D);
    exp_q.push_back(8'h00);
    applyStimulus({8'h9F, 32'h0}, 1, 3);
    checkOutput("id_no_err", 32'(err_pulses), 32'd0);
    checkOutput("last_cmd_id", 32'(last_cmd), 32'h9F);

    // Bad opcode
    applyStimulus({8'h55, 32'h0}, 1, 2);
    checkOutput("bad_err_pulses", 32'(err_pulses), 32'd1);
    checkOutput("last_cmd_bad", 32'(last_cmd), 32'h55);
    exp_q.push_back(8'hA5);
    applyStimulus({8'h03, 8'h00, 8'h10, 16'h0000}, 3, 1);

    // Aborted write leaves the prior value
    applyStimulus({8'h02, 8'h00, 8'h20, 8'h77, 8'h00}, 4, 0);
    startFrame();
    sendBits(8'h02, 8);
    sendBits(8'h00, 8);
    sendBits(8'h20, 8);
    sendBits(8'hF0, 4);
    endFrame();
    exp_q.push_back(8'h77);
    applyStimulus({8'h03, 8'h00, 8'h20, 16'h0000}, 3, 1);
    checkOutput("abort_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the address low byte
    startFrame();
    sendBits(8'h03, 8);
    sendBits(8'h00, 8);
    sendBits(8'h10, 4);
    waitClk(2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_miso", 32'(miso), 32'd0);
    checkOutput("midrst_miso_oe", 32'(miso_oe), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_last_cmd", 32'(last_cmd), 32'd0);
    waitClk(3);
    rst_n = 1'b1;
    waitClk(3);
    sendBits(8'h9F, 8);
    waitClk(6);
    checkOutput("no_decode_after_rst", 32'(last_cmd), 32'd0);
    checkOutput("no_oe_after_rst", 32'(miso_oe), 32'd0);
    endFrame();
    exp_q.push_back(8'hA5);
    applyStimulus({8'h03, 8'h00, 8'h10, 16'h0000}, 3, 1);

    checkOutput("final_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("final_err_pulses", 32'(err_pulses), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
